eth_reg_arbiter: RTL and testbench
==================================

ETH_REG_ARBITER -- requirements
Module: eth_reg_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, max consecutive reg_busy cycles per access before abort (range 1..65535).
REQ-002 clk  in  1  single clock for all logic.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rq0_req / rq1_req  in  1  access request, held until own ack.
REQ-005 rq0_wr / rq1_wr  in  1  1 = write, 0 = read.
REQ-006 rq0_addr / rq1_addr  in  8  MAC register address.
REQ-007 rq0_wdata / rq1_wdata  in  32  write data.
REQ-008 rq0_ack / rq1_ack  out  1  one-cycle completion pulse.
REQ-009 rq0_err / rq1_err  out  1  timeout flag, valid with ack.
REQ-010 rq0_rdata / rq1_rdata  out  32  read data, valid with ack.
REQ-011 reg_addr  out  8  to MAC register port.
REQ-012 reg_rd / reg_wr  out  1  MAC read/write strobes.
REQ-013 reg_data_in  out  32  write data to MAC.
REQ-014 reg_data_out  in  32  read data from MAC.
REQ-015 reg_busy  in  1  MAC wait-request.
REQ-016 timeout_cnt  out  8  saturating count of aborted accesses.

Function
REQ-017 FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-018 IDLE: no request -> stay; any rqN_req -> grant, latch wr/addr/wdata of granted port, clear busy counter, go ACCESS.
REQ-019 Arbitration round-robin: single requester wins; both requesting -> port not served last wins; last-served pointer = port 1 after reset (port 0 wins first tie).
REQ-020 ACCESS: exactly one of reg_rd/reg_wr high per latched wr; reg_addr/reg_data_in stable from latch for entire ACCESS.
REQ-021 ACCESS, reg_busy=0 sampled: transaction complete; read captures reg_data_out that cycle; go DONE.
REQ-022 ACCESS, reg_busy=1: increment busy counter; counter reaching TIMEOUT_CYC -> abort, go DONE with err set.
REQ-023 Strobes deasserted in IDLE and DONE; never both high.
REQ-024 DONE: granted port's ack=1 for exactly that cycle; err=1 only on timeout; rdata = captured data on successful read, 0 on write or timeout; then IDLE.
REQ-025 rdata/err of granted port hold until its next ack; non-granted port ack stays 0.
REQ-026 Latency: grant in IDLE cycle N -> strobe N+1 -> busy=0 at N+1 gives ack at N+2, IDLE at N+3; earliest next strobe N+4.
REQ-027 Requester drops req no later than cycle after ack; req dropped before ack does not cancel the in-flight access (still completes, ack still pulses).
REQ-028 Request changes of addr/wdata/wr after grant are ignored until next grant.
REQ-029 timeout_cnt increments by 1 per abort, saturates at 255.
REQ-030 Timeout never alters the round-robin pointer rules; aborted port counts as served.

Reset
REQ-031 Reset asserted in any state, incl. mid-ACCESS: next edge -> IDLE, reg_rd=reg_wr=0, acks=0, errs=0, rdata=0, reg_addr=0, reg_data_in=0, timeout_cnt=0, pointer=port 1; no ack for aborted access.
REQ-032 Reset dominates all other inputs in same cycle.

Verification
REQ-033 rq0 read addr 0x08, reg_busy=0, reg_data_out=0x12345678 -> reg_rd one cycle at N+1, rq0_ack at N+2, rq0_rdata=0x12345678, rq0_err=0.
REQ-034 rq1 write addr 0x3C data 0xA5A5A5A5, reg_busy high 3 cycles -> reg_wr high 4 cycles, addr/data stable, rq1_ack after busy falls, rdata=0.
REQ-035 Both req held continuously for 4 accesses from reset -> grant order 0,1,0,1; no overlapping strobes.
REQ-036 TIMEOUT_CYC=4, reg_busy stuck 1 -> strobe drops after 4 busy cycles, ack with err=1, rdata=0, timeout_cnt=1; 300 such aborts -> timeout_cnt=255.
REQ-037 Reset asserted during ACCESS with busy=1 -> next cycle strobes 0, no ack, state IDLE, subsequent rq0 read completes normally.
REQ-038 rq0 drops req one cycle after grant -> access still completes, rq0_ack pulses once, no second access issued.

Source files
------------

// File: rtl/eth_reg_arbiter.sv
// eth_reg_arbiter: two-port round-robin arbiter in front of a single MAC
// register port. Each granted access holds its strobe until the MAC drops
// reg_busy or the busy budget runs out, then pulses the winner's ack.
//
// Requester handshake: rqN_req is raised with wr/addr/wdata valid and held
// until rqN_ack pulses for one cycle; rqN_err/rqN_rdata are valid with that
// pulse and hold until the port's next ack. Request fields are sampled only
// in the grant cycle, so later changes (or dropping req) do not disturb an
// access already in flight.
module eth_reg_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rq0_req,
  input  logic        rq0_wr,
  input  logic [7:0]  rq0_addr,
  input  logic [31:0] rq0_wdata,
  output logic        rq0_ack,
  output logic        rq0_err,
  output logic [31:0] rq0_rdata,
  input  logic        rq1_req,
  input  logic        rq1_wr,
  input  logic [7:0]  rq1_addr,
  input  logic [31:0] rq1_wdata,
  output logic        rq1_ack,
  output logic        rq1_err,
  output logic [31:0] rq1_rdata,
  output logic [7:0]  reg_addr,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic [31:0] reg_data_in,
  input  logic [31:0] reg_data_out,
  input  logic        reg_busy,
  output logic [7:0]  timeout_cnt,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Busy budget compared one bit wider than the counter so 65535 fits.
  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYC);

  logic [1:0]  state_q, state_d;
  logic        gnt_q, gnt_d;      // port owning the current access
  logic        last_q, last_d;    // port served most recently
  logic        wr_q, wr_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] busy_cnt_q, busy_cnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;

  logic        gnt_sel;
  logic        cap_en;
  logic        cap_err;
  logic [31:0] cap_rdata;
  logic [16:0] busy_inc;

  // Next-state logic: arbitration, access tracking and result capture.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_cnt_d = busy_cnt_q;
    tcnt_d     = tcnt_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    err0_d     = err0_q;
    err1_d     = err1_q;
    gnt_sel    = 1'b0;
    cap_en     = 1'b0;
    cap_err    = 1'b0;
    cap_rdata  = 32'h0;
    busy_inc   = {1'b0, busy_cnt_q} + 17'd1;

    case (state_q)
      ST_IDLE: begin
        if (rq0_req || rq1_req) begin
          // On a tie the port that was not served last wins.
          if (rq0_req && rq1_req) gnt_sel = ~last_q;
          else                    gnt_sel = rq1_req;
          gnt_d      = gnt_sel;
          last_d     = gnt_sel;
          wr_d       = gnt_sel ? rq1_wr    : rq0_wr;
          addr_d     = gnt_sel ? rq1_addr  : rq0_addr;
          wdata_d    = gnt_sel ? rq1_wdata : rq0_wdata;
          busy_cnt_d = 16'h0;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!reg_busy) begin
          cap_en    = 1'b1;
          cap_rdata = wr_q ? 32'h0 : reg_data_out;
          state_d   = ST_DONE;
        end else if (busy_inc == TIMEOUT_LIM) begin
          // Budget exhausted: abort, report err, return zero data.
          cap_en  = 1'b1;
          cap_err = 1'b1;
          state_d = ST_DONE;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end else begin
          busy_cnt_d = busy_inc[15:0];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (cap_en) begin
      if (gnt_q) begin
        rdata1_d = cap_rdata;
        err1_d   = cap_err;
      end else begin
        rdata0_d = cap_rdata;
        err0_d   = cap_err;
      end
    end
  end

  // State registers; reset abandons any in-flight access without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= 8'h0;
      wdata_q    <= 32'h0;
      busy_cnt_q <= 16'h0;
      tcnt_q     <= 8'h0;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_cnt_q <= busy_cnt_d;
      tcnt_q     <= tcnt_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

  assign reg_rd      = (state_q == ST_ACCESS) && !wr_q;
  assign reg_wr      = (state_q == ST_ACCESS) &&  wr_q;
  assign reg_addr    = addr_q;
  assign reg_data_in = wdata_q;
  assign rq0_ack     = (state_q == ST_DONE) && !gnt_q;
  assign rq1_ack     = (state_q == ST_DONE) &&  gnt_q;
  assign rq0_err     = err0_q;
  assign rq1_err     = err1_q;
  assign rq0_rdata   = rdata0_q;
  assign rq1_rdata   = rdata1_q;
  assign timeout_cnt = tcnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_eth_reg_arbiter.sv
// Bench for eth_reg_arbiter: vector table, hand sequences for reset,
// arbitration order and early req drop, then random accesses against a
// transaction-level model. Inputs change and outputs are sampled on negedge.
module tb_eth_reg_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rq0_req, rq0_wr, rq1_req, rq1_wr;
  logic [7:0]  rq0_addr, rq1_addr;
  logic [31:0] rq0_wdata, rq1_wdata;
  logic        rq0_ack, rq0_err, rq1_ack, rq1_err;
  logic [31:0] rq0_rdata, rq1_rdata;
  logic [7:0]  reg_addr;
  logic        reg_rd, reg_wr;
  logic [31:0] reg_data_in, reg_data_out;
  logic        reg_busy;
  logic [7:0]  timeout_cnt;
  logic [1:0]  dbg_state;

  eth_reg_arbiter #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset),
    .rq0_req(rq0_req), .rq0_wr(rq0_wr), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_ack(rq0_ack), .rq0_err(rq0_err), .rq0_rdata(rq0_rdata),
    .rq1_req(rq1_req), .rq1_wr(rq1_wr), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_ack(rq1_ack), .rq1_err(rq1_err), .rq1_rdata(rq1_rdata),
    .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .reg_data_in(reg_data_in), .reg_data_out(reg_data_out), .reg_busy(reg_busy),
    .timeout_cnt(timeout_cnt), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;

  // Model state: held results per port and the saturating abort count.
  logic [31:0] held_rdata[2];
  logic        held_err[2];
  int          tcnt_m;

  typedef struct {
    int          p;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          busy_n;
    logic [31:0] mac;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_ack;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // Safety invariants watched every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_rd && reg_wr) viol++;
      if (rq0_ack && rq1_ack) viol++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive_port(input int p, input bit req, input bit wr,
                            input logic [7:0] a, input logic [31:0] d);
    if (p == 0) begin
      rq0_req = req; rq0_wr = wr; rq0_addr = a; rq0_wdata = d;
    end else begin
      rq1_req = req; rq1_wr = wr; rq1_addr = a; rq1_wdata = d;
    end
  endtask

  task automatic model_reset();
    held_rdata[0] = 32'h0; held_rdata[1] = 32'h0;
    held_err[0] = 1'b0; held_err[1] = 1'b0;
    tcnt_m = 0;
  endtask

  // One single-port access starting with the DUT idle, at a negedge.
  task automatic run_txn(input int p, input bit wr, input logic [7:0] addr,
                         input logic [31:0] wdata, input int busy_n,
                         input logic [31:0] mac, input int drop_at,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input int exp_ack, input string tag);
    int strobes = 0;
    int ack_at = 0;
    bit stable_ok = 1'b1;
    int o = 1 - p;
    drive_port(o, 1'b0, 1'b0, 8'h0, 32'h0);
    drive_port(p, 1'b1, wr, addr, wdata);
    reg_busy = 1'b0;
    reg_data_out = 32'h0;
    for (int s = 1; s <= 40 && ack_at == 0; s++) begin
      @(negedge clk);
      if (s == 1) begin
        // Scramble request fields after grant; the access must not notice.
        if (p == 0) begin rq0_addr = 8'($urandom); rq0_wdata = $urandom; rq0_wr = 1'($urandom); end
        else        begin rq1_addr = 8'($urandom); rq1_wdata = $urandom; rq1_wr = 1'($urandom); end
      end
      if (drop_at == s) begin
        if (p == 0) rq0_req = 1'b0; else rq1_req = 1'b0;
      end
      if (reg_rd || reg_wr) begin
        strobes++;
        if (reg_addr !== addr || reg_data_in !== wdata || reg_wr !== wr) stable_ok = 1'b0;
        reg_busy = (strobes <= busy_n);
        reg_data_out = reg_busy ? ~mac : mac;
      end else begin
        reg_busy = 1'b0;
        reg_data_out = 32'h0;
      end
      if ((p == 0) ? rq0_ack : rq1_ack) begin
        ack_at = s;
        if (exp_err && tcnt_m < 255) tcnt_m++;
        check({tag, "_err"},   (p == 0) ? rq0_err : rq1_err, exp_err);
        check({tag, "_rdata"}, (p == 0) ? rq0_rdata : rq1_rdata, exp_rdata);
        check({tag, "_tcnt"},  timeout_cnt, tcnt_m);
        if (p == 0) rq0_req = 1'b0; else rq1_req = 1'b0;
      end
    end
    check({tag, "_ack_cycle"}, ack_at, exp_ack);
    check({tag, "_strobes"}, strobes, exp_ack - 1);
    check({tag, "_stable"}, stable_ok, 1'b1);
    held_rdata[p] = exp_rdata;
    held_err[p] = exp_err;
    check({tag, "_other_rdata"}, (o == 0) ? rq0_rdata : rq1_rdata, held_rdata[o]);
    check({tag, "_other_err"}, (o == 0) ? rq0_err : rq1_err, held_err[o]);
    reg_busy = 1'b0;
    reg_data_out = 32'h0;
    @(negedge clk);
  endtask

  // Both ports request writes continuously; record the ack order.
  task automatic run_tie(input int n, input int first, input string tag);
    int got[$];
    drive_port(0, 1'b1, 1'b1, 8'h50, 32'h0000_0050);
    drive_port(1, 1'b1, 1'b1, 8'h51, 32'h0000_0051);
    reg_busy = 1'b0;
    for (int s = 0; s < 80 && got.size() < n; s++) begin
      @(negedge clk);
      if (rq0_ack) got.push_back(0);
      if (rq1_ack) got.push_back(1);
      if (got.size() >= n) begin
        rq0_req = 1'b0;
        rq1_req = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_order_%0d", tag, i), (i < got.size()) ? got[i] : -1, (first + i) % 2);
    held_rdata[0] = 32'h0; held_rdata[1] = 32'h0;
    held_err[0] = 1'b0; held_err[1] = 1'b0;
  endtask

  // Expected outcome derived from the busy budget rules.
  task automatic predict(input bit wr, input int busy_n, input logic [31:0] mac,
                         output logic e_err, output logic [31:0] e_rdata, output int e_ack);
    e_err = (busy_n >= T);
    e_rdata = (e_err || wr) ? 32'h0 : mac;
    e_ack = (e_err ? T : busy_n + 1) + 1;
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 8'h08, 32'h0,         0, 32'h1234_5678, 1'b0, 32'h1234_5678, 2};
    vecs[1] = '{1, 1'b1, 8'h3C, 32'hA5A5_A5A5, 3, 32'h0000_0000, 1'b0, 32'h0,         5};
    vecs[2] = '{0, 1'b0, 8'h10, 32'h0,         4, 32'h1111_1111, 1'b1, 32'h0,         5};
    vecs[3] = '{1, 1'b0, 8'h20, 32'h0,         2, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4};
    vecs[4] = '{0, 1'b1, 8'hFF, 32'h0F0F_0F0F, 1, 32'hCAFE_BABE, 1'b0, 32'h0,         3};
    vecs[5] = '{1, 1'b0, 8'h04, 32'h0,         9, 32'h55AA_55AA, 1'b1, 32'h0,         5};
    vecs[6] = '{0, 1'b0, 8'h00, 32'h0,         3, 32'h8765_4321, 1'b0, 32'h8765_4321, 5};

    // Reset state
    reset = 1'b1;
    drive_port(0, 1'b0, 1'b0, 8'h0, 32'h0);
    drive_port(1, 1'b0, 1'b0, 8'h0, 32'h0);
    reg_busy = 1'b0;
    reg_data_out = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_strobes", {reg_rd, reg_wr}, 2'b00);
    check("rst_acks", {rq0_ack, rq1_ack}, 2'b00);
    check("rst_errs", {rq0_err, rq1_err}, 2'b00);
    check("rst_addr", reg_addr, 8'h0);
    check("rst_tcnt", timeout_cnt, 8'h0);
    check("rst_state_idle", dbg_state, 2'd0);
    reset = 1'b0;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].p, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].busy_n,
              vecs[i].mac, 0, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_ack,
              $sformatf("vec%0d", i));

    // Reset in the middle of a busy access
    drive_port(0, 1'b1, 1'b0, 8'h44, 32'h0);
    reg_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_strobe_before", reg_rd, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_strobes", {reg_rd, reg_wr}, 2'b00);
    check("midrst_acks", {rq0_ack, rq1_ack}, 2'b00);
    check("midrst_rdata0", rq0_rdata, 32'h0);
    check("midrst_rdata_err", {rq1_rdata, rq0_err, rq1_err}, 34'h0);
    check("midrst_addr_data", {reg_addr, reg_data_in}, 40'h0);
    check("midrst_tcnt", timeout_cnt, 8'h0);
    check("midrst_state_idle", dbg_state, 2'd0);
    reset = 1'b0;
    rq0_req = 1'b0;
    reg_busy = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_no_late_ack", {rq0_ack, rq1_ack}, 2'b00);
    run_txn(0, 1'b0, 8'h08, 32'h0, 1, 32'h0BAD_F00D, 0, 1'b0, 32'h0BAD_F00D, 3, "post_rst");

    // Round-robin from reset, then a timeout counts as served
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_tie(4, 0, "tie_rst");
    run_txn(0, 1'b0, 8'h60, 32'h0, T, 32'h7777_7777, 0, 1'b1, 32'h0, T + 1, "pre_tie_abort");
    run_tie(2, 1, "tie_after_abort");

    // Requester drops req the cycle after grant
    begin
      int extra = 0;
      run_txn(0, 1'b0, 8'h30, 32'h0, 2, 32'h1357_9BDF, 1, 1'b0, 32'h1357_9BDF, 4, "drop");
      for (int s = 0; s < 6; s++) begin
        @(negedge clk);
        if (reg_rd || reg_wr || rq0_ack || rq1_ack) extra++;
      end
      check("drop_no_second_access", extra, 0);
    end

    // Random accesses against the model
    for (int i = 0; i < 60; i++) begin
      int p, busy_n, drop_at, e_ack;
      bit wr;
      logic [7:0] a;
      logic [31:0] d, mac, e_rdata;
      logic e_err;
      p = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      d = $urandom;
      mac = $urandom;
      busy_n = $urandom_range(0, 6);
      predict(wr, busy_n, mac, e_err, e_rdata, e_ack);
      drop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, e_ack) : 0;
      run_txn(p, wr, a, d, busy_n, mac, drop_at, e_err, e_rdata, e_ack, $sformatf("rnd%0d", i));
    end

    // Abort count saturates
    for (int i = 0; i < 300; i++)
      run_txn(i % 2, 1'b0, 8'h70, 32'h0, T + 2, 32'hFFFF_0000, 0, 1'b1, 32'h0, T + 1,
              $sformatf("sat%0d", i));
    check("tcnt_saturated", timeout_cnt, 8'd255);

    check("no_overlap_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
